seq_shift_add_mult: RTL

- Sequential unsigned N×N multiplier controller built around one shared N-bit ripple-carry adder made of full-adder cells.
- Applies the adder once per multiplier bit, using a shift-and-add scheme, and delivers a 2N-bit product.
- Sits between the operand switch/register bank and the result LED/display logic.
- It is the sequencing layer that turns the combinational adder datapath into a multiplier.

---
 rtl/seq_mult_pkg.sv | 32 +++
 rtl/nbit_ripple_adder.sv | 36 +++
 rtl/seq_shift_add_mult.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package    : seq_mult_pkg
// Purpose    : Shared types and helpers for the sequential shift-and-add
//              multiplier: controller state encoding and a constant
//              ceil(log2) used to size the iteration counter.
// Revision   : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

  // Controller states. Encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ceil(log2(value)); callers only pass value >= 2, so the result is >= 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nbit_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module     : nbit_ripple_adder
// Purpose    : Purely combinational N-bit ripple-carry adder built from a
//              chain of N full-adder cells.
// Ports      : a    [N-1:0] in  - first operand
//              b    [N-1:0] in  - second operand
//              cin          in  - carry into bit 0
//              sum  [N-1:0] out - N-bit sum
//              cout         out - carry out of bit N-1
// Revision   : 1.0 - initial release
// ============================================================================
module nbit_ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // w_carry[i] is the carry into cell i; w_carry[N] leaves the chain.
  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module     : seq_shift_add_mult
// Purpose    : Sequential unsigned NxN multiplier. One shared N-bit ripple
//              adder is applied once per multiplier bit (shift-and-add); the
//              2N-bit product is registered on the final iteration and held
//              until the next completion.
// Ports      : clk              in  - system clock, rising edge
//              rst_n            in  - asynchronous active-low reset
//              start            in  - launch request, sampled in IDLE/DONE
//              a       [N-1:0]  in  - multiplicand, captured on launch
//              b       [N-1:0]  in  - multiplier, captured on launch
//              busy             out - high while iterating (RUN)
//              done             out - one-cycle pulse, product just updated
//              product [2N-1:0] out - last completed result
// Revision   : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CNT_W = clog2(N);

  state_e           state_q,   state_d;
  logic [N-1:0]     mcand_q,   mcand_d;
  // Upper partial product. After every shift its carry position is
  // structurally zero ({1'b0, c, s[N-1:1]}), so only the N live bits are
  // stored; the adder carry lands in the MSB.
  logic [N-1:0]     acc_q,     acc_d;
  logic [N-1:0]     q_q,       q_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;
  logic             w_cout;
  logic             w_launch;

  // The one and only adder: accumulator plus the gated multiplicand.
  assign w_addend = q_q[0] ? mcand_q : '0;

  nbit_ripple_adder #(
    .N (N)
  ) u_adder (
    .a    (acc_q),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // start is honoured only when not iterating; DONE relaunches back-to-back.
  assign w_launch = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_launch) begin
          state_d = RUN;
        end
      end

      RUN: begin
        busy  = 1'b1;
        // {acc,q} <= {c,s,q} >> 1
        acc_d = {w_cout, w_sum[N-1:1]};
        q_d   = {w_sum[0], q_q[N-1:1]};
        if (cnt_q == '0) begin
          product_d = {w_cout, w_sum, q_q[N-1:1]};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = w_launch ? RUN : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture shared by the IDLE and DONE launch paths.
    if (w_launch) begin
      mcand_d = a;
      q_d     = b;
      acc_d   = '0;
      cnt_d   = CNT_W'(N - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
`default_nettype wire
